// File: rtl/series_eval_arbiter.sv
// Round-robin arbiter sharing one iterative series-evaluation engine among N_REQ requesters.
// Optional WAIT timeout is enabled by defining SERIES_ARB_TIMEOUT_EN.
module series_eval_arbiter #(
  parameter int N_REQ       = 4,
  parameter int X_W         = 16,
  parameter int Y_W         = 8,
  parameter int START_CYC   = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*X_W-1:0]       req_x,
  input  logic [N_REQ*Y_W-1:0]       req_y,
  output logic [N_REQ-1:0]           ack,
  output logic [X_W-1:0]             res_data,
  output logic                       err,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       eng_start,
  output logic [X_W-1:0]             eng_x,
  output logic [Y_W-1:0]             eng_y,
  input  logic [X_W-1:0]             eng_ans,
  input  logic                       eng_done
);

  localparam int IW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || START_CYC < 1 || START_CYC > 15 || TIMEOUT_CYC < 1)
  begin : g_bad_param
    $error("series_eval_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_q;
  logic [IW-1:0]     ptr_q;
  logic [IW-1:0]     grant_id_q;
  logic [N_REQ-1:0]  ack_q;
  logic [X_W-1:0]    res_data_q;
  logic [X_W-1:0]    eng_x_q;
  logic [Y_W-1:0]    eng_y_q;
  logic              eng_start_q;
  logic              busy_q;
  logic              armed_q;
  logic [3:0]        scnt_q;
  logic [IW-1:0]     win_d;
  logic              hit_d;

`ifdef SERIES_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0]     wcnt_q;
  logic              err_q;
`endif

  // First set request at or above the pointer, wrapping at N_REQ.
  always_comb begin
    int idx;
    idx   = 0;
    win_d = ptr_q;
    hit_d = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (!hit_d && req[idx]) begin
        hit_d = 1'b1;
        win_d = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_id_q  <= '0;
      ack_q       <= '0;
      res_data_q  <= '0;
      eng_x_q     <= '0;
      eng_y_q     <= '0;
      eng_start_q <= 1'b0;
      busy_q      <= 1'b0;
      armed_q     <= 1'b0;
      scnt_q      <= '0;
`ifdef SERIES_ARB_TIMEOUT_EN
      wcnt_q      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= '0;
          // The ack cycle itself never grants, giving the requester a cycle to drop req.
          if (ack_q == '0 && hit_d) begin
            grant_id_q  <= win_d;
            eng_x_q     <= req_x[win_d*X_W +: X_W];
            eng_y_q     <= req_y[win_d*Y_W +: Y_W];
            eng_start_q <= 1'b1;
            scnt_q      <= 4'd1;
            armed_q     <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          if (!eng_done) armed_q <= 1'b1;
          if (scnt_q == 4'(START_CYC)) begin
            eng_start_q <= 1'b0;
            state_q     <= WAIT;
`ifdef SERIES_ARB_TIMEOUT_EN
            wcnt_q      <= '0;
`endif
          end else begin
            scnt_q <= scnt_q + 4'd1;
          end
        end
        WAIT: begin
          if (!eng_done) armed_q <= 1'b1;
          // Done only counts once it has been seen low during this operation.
          if (eng_done && armed_q) begin
            res_data_q <= eng_ans;
            state_q    <= RESP;
`ifdef SERIES_ARB_TIMEOUT_EN
            err_q      <= 1'b0;
          end else if (wcnt_q == TW'(TIMEOUT_CYC - 1)) begin
            res_data_q <= '0;
            err_q      <= 1'b1;
            state_q    <= RESP;
          end else begin
            wcnt_q <= wcnt_q + TW'(1);
`endif
          end
        end
        RESP: begin
          ack_q   <= {{(N_REQ-1){1'b0}}, 1'b1} << grant_id_q;
          ptr_q   <= (grant_id_q == IW'(N_REQ - 1)) ? '0 : grant_id_q + IW'(1);
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack       = ack_q;
  assign res_data  = res_data_q;
  assign busy      = busy_q;
  assign grant_id  = grant_id_q;
  assign eng_start = eng_start_q;
  assign eng_x     = eng_x_q;
  assign eng_y     = eng_y_q;
`ifdef SERIES_ARB_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_series_eval_arbiter.sv
// Scoreboard bench for series_eval_arbiter with a behavioural sine engine
// whose results are a table of hand-computed Q8.8 values.
module tb_series_eval_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [63:0] req_x;
  logic [31:0] req_y;
  logic [3:0]  ack;
  logic [15:0] res_data;
  logic        err;
  logic        busy;
  logic [1:0]  grant_id;
  logic        eng_start;
  logic [15:0] eng_x;
  logic [7:0]  eng_y;
  logic [15:0] eng_ans  = 16'h0000;
  logic        eng_done = 1'b0;

  always #5 clk = ~clk;

  series_eval_arbiter #(
    .N_REQ(4), .X_W(16), .Y_W(8), .START_CYC(2), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_x(req_x), .req_y(req_y),
    .ack(ack), .res_data(res_data), .err(err), .busy(busy), .grant_id(grant_id),
    .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y),
    .eng_ans(eng_ans), .eng_done(eng_done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Engine model: sin(x) in Q8.8, done level held until dropped after the next start.
  function automatic logic [15:0] sin_tab(input logic [15:0] x);
    case (x)
      16'h00a0: return 16'h0096;
      16'h00c8: return 16'h00b4;
      16'h010c: return 16'h00de;
      16'h0191: return 16'h0100;
      16'h0324: return 16'h0000;
      default:  return 16'hdead;
    endcase
  endfunction

  int          lat = 20;
  int          drop_delay = 1;
  bit          never_done = 1'b0;
  logic        start_d = 1'b0;
  bit          e_busy = 1'b0;
  int          lat_cnt = 0;
  int          drop_cnt = 0;
  logic [15:0] x_cap = 16'h0;

  always @(posedge clk) begin
    start_d <= eng_start;
    if (eng_start && !start_d) begin
      e_busy   <= !never_done;
      lat_cnt  <= lat;
      drop_cnt <= drop_delay;
      x_cap    <= eng_x;
    end else begin
      if (drop_cnt > 0) begin
        drop_cnt <= drop_cnt - 1;
        if (drop_cnt == 1) eng_done <= 1'b0;
      end
      if (e_busy) begin
        if (lat_cnt <= 1) begin
          e_busy   <= 1'b0;
          eng_done <= 1'b1;
          eng_ans  <= sin_tab(x_cap);
        end else begin
          lat_cnt <= lat_cnt - 1;
        end
      end
    end
  end

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t sb_q[$];

  task automatic expect_resp(input logic [1:0] id, input logic [15:0] data, input logic e);
    sb_q.push_back(exp_t'{id: id, data: data, err: e});
  endtask

  // Monitor: every ack pulse is matched against the oldest expected response.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ack != 4'b0000) begin
      check("ack_onehot", 32'($onehot(ack)), 32'd1);
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_ack: got ack=%b expected none", ack);
      end else begin
        e = sb_q.pop_front();
        check("ack_id", 32'(ack), 32'(4'b0001 << e.id));
        check("res_data", 32'(res_data), 32'(e.data));
        check("err", 32'(err), 32'(e.err));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (eng_start) begin ok = 1'b1; break; end
    end
    if (!ok) begin n_tests++; n_fail++; $display("FAIL start_timeout: got no eng_start expected one"); end
  endtask

  task automatic wait_start_fall();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!eng_start) begin ok = 1'b1; break; end
    end
    if (!ok) begin n_tests++; n_fail++; $display("FAIL start_stuck: got eng_start=1 expected 0"); end
  endtask

  task automatic wait_ack(output logic [3:0] a);
    a = 4'b0000;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ack != 4'b0000) begin a = ack; break; end
    end
    if (a == 4'b0000) begin n_tests++; n_fail++; $display("FAIL ack_timeout: got no ack expected one"); end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"}, 32'(ack), 32'd0);
    check({tag, "_res_data"}, 32'(res_data), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    check({tag, "_eng_start"}, 32'(eng_start), 32'd0);
    check({tag, "_eng_x"}, 32'(eng_x), 32'd0);
    check({tag, "_eng_y"}, 32'(eng_y), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    logic [3:0]  a;
    int          cnt;
    bit          early;

    rst_n = 1'b0; req = '0; req_x = '0; req_y = '0;
    tick(2);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(2);

    // Single request
    expect_resp(2'd0, 16'h0096, 1'b0);
    req_x[15:0] = 16'h00a0; req_y[7:0] = 8'h00; req = 4'b0001;
    wait_start(ok);
    check("t1_eng_x", 32'(eng_x), 32'h00a0);
    check("t1_grant_id", 32'(grant_id), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    cnt = 0;
    while (eng_start && cnt < 20) begin cnt++; @(negedge clk); end
    check("t1_start_cycles", 32'(cnt), 32'd2);
    wait_ack(a);
    req &= ~a;
    tick(2);
    check("t1_busy_after", 32'(busy), 32'd0);

    // Rotation with all requesters asserted, starting from a reset pointer
    rst_n = 1'b0; tick(1); rst_n = 1'b1; tick(1);
    req_x = {16'h0324, 16'h0191, 16'h010c, 16'h00c8};
    req_y = {8'h44, 8'h33, 8'h22, 8'h11};
    expect_resp(2'd0, 16'h00b4, 1'b0);
    expect_resp(2'd1, 16'h00de, 1'b0);
    expect_resp(2'd2, 16'h0100, 1'b0);
    expect_resp(2'd3, 16'h0000, 1'b0);
    expect_resp(2'd0, 16'h00b4, 1'b0);
    req = 4'b1111;
    wait_start(ok);
    check("t2_eng_y", 32'(eng_y), 32'h11);
    for (int i = 0; i < 5; i++) wait_ack(a);
    req = 4'b0000;
    tick(3);

    // Operand change during WAIT is ignored
    expect_resp(2'd1, 16'h0100, 1'b0);
    req_x[31:16] = 16'h0191; req = 4'b0010;
    wait_start(ok);
    wait_start_fall();
    req_x[31:16] = 16'h0000;
    tick(3);
    check("t4_eng_x_held", 32'(eng_x), 32'h0191);
    wait_ack(a);
    req = 4'b0000;
    tick(3);

    // Stale done held from the previous operation
    drop_delay = 3;
    expect_resp(2'd2, 16'h00de, 1'b0);
    req_x[47:32] = 16'h010c; req = 4'b0100;
    wait_start(ok);
    early = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack != 4'b0000) early = 1'b1;
    end
    check("t3_no_early_ack", 32'(early), 32'd0);
    wait_ack(a);
    req = 4'b0000;
    drop_delay = 1;
    tick(3);

    // Asynchronous reset in the middle of WAIT
    req_x[63:48] = 16'h00c8; req = 4'b1000;
    wait_start(ok);
    wait_start_fall();
    tick(2);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    req = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("t5_sb_empty", 32'(sb_q.size()), 32'd0);
    expect_resp(2'd2, 16'h0000, 1'b0);
    expect_resp(2'd3, 16'h0096, 1'b0);
    req_x[47:32] = 16'h0324; req_x[63:48] = 16'h00a0; req = 4'b1100;
    wait_ack(a);
    req &= ~a;
    wait_ack(a);
    req &= ~a;
    tick(3);

`ifdef SERIES_ARB_TIMEOUT_EN
    // Engine never finishes: timeout response, then the next requester is served
    never_done = 1'b1;
    expect_resp(2'd0, 16'h0000, 1'b1);
    expect_resp(2'd1, 16'h00de, 1'b0);
    req_x[15:0] = 16'h00a0; req_x[31:16] = 16'h010c; req = 4'b0011;
    wait_start(ok);
    wait_start_fall();
    cnt = 0;
    while (ack == 4'b0000 && cnt < 40) begin cnt++; @(negedge clk); end
    check("t6_timeout_cycles", 32'(cnt), 32'd17);
    req &= ~ack;
    never_done = 1'b0;
    wait_ack(a);
    req = 4'b0000;
    tick(3);
`endif

    tick(5);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/series_eval_arbiter.md
Name: series_eval_arbiter

Overview:
- Shares one iterative series-evaluation engine among N_REQ requesters.
- The engine has a start/x/in_y/ans/done interface: 16-bit fixed-point angle with 8 fractional bits, 8-bit auxiliary operand, 16-bit result.
- Round-robin arbitration; captures the winner's operands, drives the multi-cycle start pulse, waits for done, then returns the result with a one-cycle ack.
- Sits between the trig/series consumers and the single engine instance.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- X_W, 16, angle operand / result width
- Y_W, 8, auxiliary operand width
- START_CYC, 2, cycles eng_start is held high per operation (1..15)
- TIMEOUT_CYC, 255, WAIT-state cycle limit (used only with the optional feature)

Ports:
- clk  in  1  clock, rising-edge
- rst_n  in  1  asynchronous active-low reset
- req  in  N_REQ  per-requester request, level, held until its ack
- req_x  in  N_REQ*X_W  packed angle operands, requester i at [i*X_W +: X_W]
- req_y  in  N_REQ*Y_W  packed aux operands, same packing
- ack  out  N_REQ  one-cycle pulse to the served requester
- res_data  out  X_W  result; valid only in the ack cycle
- err  out  1  timeout flag; valid only in the ack cycle
- busy  out  1  high in every state except IDLE
- grant_id  out  $clog2(N_REQ)  index of the current or last granted requester
- eng_start  out  1  engine start
- eng_x  out  X_W  engine angle operand (registered)
- eng_y  out  Y_W  engine aux operand (registered)
- eng_ans  in  X_W  engine result
- eng_done  in  1  engine done, level

Behaviour:
- Clocking and reset: one clock clk; reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, round-robin pointer 0, internal counters 0. Reset mid-operation aborts immediately: no ack is issued and the engine is left to finish unobserved.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is high, select the first set bit searching from the pointer upward, wrapping at N_REQ.
  - Register grant_id, eng_x and eng_y from the winner's slices; go to ISSUE.
  - Operands are captured only here; later changes to req_x/req_y are ignored.
- ISSUE:
  - eng_start=1 for exactly START_CYC cycles, counted from the first ISSUE cycle; then go to WAIT with eng_start=0.
  - An armed flag is cleared on ISSUE entry and set when eng_done==0 is sampled at any time in ISSUE or WAIT. This rejects a stale done left over from the previous operation.
- WAIT: when eng_done==1 and armed==1, register res_data<=eng_ans and go to RESP.
- RESP (one cycle):
  - ack[grant_id]=1; res_data and err valid.
  - Pointer <= grant_id+1, wrapping from N_REQ-1 to 0; go to IDLE.
- Latency: req sampled in IDLE at edge 0 → eng_start high after edges 1..START_CYC. Done sampled at edge k → ack high in the cycle after edge k+1. Next grant is evaluated in IDLE on the following edge (one idle cycle minimum between operations).
- Requester rules:
  - Drop req no later than the cycle after ack; req still high one cycle after ack counts as a new request.
  - A req withdrawn mid-operation does not abort: the operation completes and the ack pulse is still issued (result discarded).
- Fairness: with all requests continuously asserted, grants rotate 0,1,...,N_REQ-1,0. No requester waits more than N_REQ-1 operations.
- ack is one-hot or zero. eng_x and eng_y hold their last value outside ISSUE/WAIT.

Optional Feature:
- Macro SERIES_ARB_TIMEOUT_EN.
- Defined: a WAIT-cycle counter runs. If it reaches TIMEOUT_CYC without an accepted done, go to RESP with res_data=16'h0000 and err=1; the pointer advances normally.
- Not defined: no counter; WAIT waits indefinitely; err is tied 0.

Test Plan:
1. Single request: req[0]=1, x=16'h00a0, y=0; engine model returns 16'h0096 after 20 cycles → eng_x=16'h00a0, eng_start high exactly 2 cycles, ack[0] one pulse with res_data=16'h0096, busy back to 0.
2. All four requesting continuously, x=16'h00c8/16'h010c/16'h0191/16'h0324 → grant order 0,1,2,3,0; each ack carries the matching model result.
3. Stale done: the engine holds done=1 from the previous op and drops it 3 cycles after start → no ack before done falls then rises; correct result.
4. Operand change: req_x[1] changes from 16'h0191 to 16'h0000 during WAIT → eng_x stays 16'h0191 and the result matches 16'h0191.
5. Reset mid-WAIT: rst_n low for 1 cycle → all outputs 0 asynchronously, no ack for the aborted op; next req[2] is granted normally with pointer 0.
6. With SERIES_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, the engine never asserts done → ack after 16 WAIT cycles with err=1, res_data=0; the next requester is served.
